// File: rtl/rca4b_pkg.sv
// Shared constants for the rca4b ripple-carry adder slice.
package rca4b_pkg;

   // Operand width the adder is built and verified at.
   localparam int unsigned RcaWidth = 4;

endpackage : rca4b_pkg

// File: rtl/full_adder.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module full_adder
   import rca4b_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   // Sum and carry for one bit; p is the propagate term shared by both.
   always_comb begin
      p  = a ^ b;
      s  = p ^ ci;
      co = (a & b) | (ci & p);
   end

endmodule : full_adder

// File: rtl/rca4b.sv
// 4-bit ripple-carry adder with one registered output stage: {co,s} = a + b + c.
module rca4b
   import rca4b_pkg::*;
#(
   parameter int unsigned WIDTH = RcaWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] s_d, s_q;
   logic             co_d, co_q;

   assign carry[0] = c;

   // Carry chain runs LSB to MSB; carry[WIDTH] is the final carry-out.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end : g_fa

   // Next-state of the output register is the settled ripple result.
   always_comb begin
      s_d  = sum;
      co_d = carry[WIDTH];
   end

   // Output register; asynchronous reset discards any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= '0;
         co_q <= 1'b0;
      end else begin
         s_q  <= s_d;
         co_q <= co_d;
      end
   end

   assign s  = s_q;
   assign co = co_q;

endmodule : rca4b

// File: tb/tb_rca4b.sv
// Scoreboard bench for rca4b: the driver queues expected {co,s}, the monitor checks after each edge.
module tb_rca4b;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       c;
   logic [3:0] s;
   logic       co;

   typedef struct {
      logic [4:0] exp;
      string      name;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        n_checks = 0;
   int        n_fails  = 0;

   rca4b #(
      .WIDTH (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .s     (s),
      .co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got {co,s}=%h, expected %h", nm, act, exp);
      end
   endtask

   // Drive one vector on the falling edge and queue the value due after the next rising edge.
   task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                        input logic [4:0] exp, input string nm);
      sb_entry_t e;
      @(negedge clk);
      a = av;
      b = bv;
      c = cv;
      e.exp  = exp;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   // Monitor: one result per rising edge, checked just after the edge.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, {co, s}, e.exp);
         end
      end
   end

   initial begin
      sb_entry_t e;
      logic [4:0] model;
      rst_n = 1'b1;
      a = 4'hF;
      b = 4'hF;
      c = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_async", {co, s}, 5'h00);

      // Clock runs with max inputs while reset is held: outputs stay zero.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset_hold", {co, s}, 5'h00);
      end

      // Release; first capture sees F+F+1.
      @(negedge clk);
      rst_n = 1'b1;
      e.exp  = 5'h1F;
      e.name = "reset_release";
      sb_q.push_back(e);

      // Basic sweep.
      drive(4'h0, 4'h0, 1'b1, 5'h01, "sweep_001");
      drive(4'h0, 4'h1, 1'b0, 5'h01, "sweep_010");
      drive(4'h0, 4'h1, 1'b1, 5'h02, "sweep_011");
      drive(4'h1, 4'h0, 1'b0, 5'h01, "sweep_100");
      drive(4'h1, 4'h0, 1'b1, 5'h02, "sweep_101");
      drive(4'h1, 4'h1, 1'b0, 5'h02, "sweep_110");
      drive(4'h1, 4'h1, 1'b1, 5'h03, "sweep_111");

      // Carry ripple and boundaries.
      drive(4'h7, 4'h8, 1'b1, 5'h10, "ripple_781");
      drive(4'h5, 4'hA, 1'b0, 5'h0F, "ripple_5a0");
      drive(4'hF, 4'hF, 1'b1, 5'h1F, "bound_max");
      drive(4'hF, 4'h0, 1'b1, 5'h10, "bound_wrap");
      drive(4'h0, 4'h0, 1'b0, 5'h00, "bound_zero");

      // Exhaustive, back-to-back one vector per cycle.
      for (int i = 0; i < 512; i++) begin
         model = 5'(i[8:5]) + 5'(i[4:1]) + 5'(i[0]);
         drive(i[8:5], i[4:1], i[0], model, "exhaustive");
      end

      // Asynchronous reset between edges while s=F.
      drive(4'hF, 4'h0, 1'b0, 5'h0F, "pre_reset");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midstream_reset", {co, s}, 5'h00);
      @(negedge clk);
      a = 4'h3;
      b = 4'h4;
      c = 1'b0;
      check("midstream_hold", {co, s}, 5'h00);
      @(negedge clk);
      check("midstream_hold2", {co, s}, 5'h00);
      rst_n = 1'b1;
      e.exp  = 5'h07;
      e.name = "post_reset_capture";
      sb_q.push_back(e);
      drive(4'h9, 4'h9, 1'b1, 5'h13, "post_reset_next");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_rca4b
